// File: rtl/unidade_controle_genius_param.sv
// rtl/unidade_controle_genius_param.sv - memory-game control unit: replay, move check, append, lives and timeouts
module unidade_controle_genius_param #(
    parameter int ADDR_W      = 4,
    parameter int N_ROUNDS    = 16,
    parameter int TIMEOUT_CYC = 5000,
    parameter int SHOW_CYC    = 1000,
    parameter int LIVES       = 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         iniciar,
    input  logic                         modo,
    input  logic                         jogada,
    input  logic                         igual,
    output logic [ADDR_W-1:0]            endereco,
    output logic [ADDR_W-1:0]            rodada,
    output logic                         zeraR,
    output logic                         registraR,
    output logic                         we,
    output logic                         mostra_led,
    output logic [$clog2(LIVES+1)-1:0]   vidas,
    output logic                         acertou,
    output logic                         errou,
    output logic                         timeout,
    output logic                         pronto,
    output logic [4:0]                   db_estado
);

    localparam int MAX_CYC = (TIMEOUT_CYC > SHOW_CYC) ? TIMEOUT_CYC : SHOW_CYC;
    localparam int TW      = $clog2(MAX_CYC);
    localparam int VW      = $clog2(LIVES + 1);

    localparam logic [TW-1:0]     SHOW_FIM   = TW'(SHOW_CYC - 1);
    localparam logic [TW-1:0]     TEMPO_FIM  = TW'(TIMEOUT_CYC - 1);
    localparam logic [ADDR_W-1:0] RODADA_FIM = ADDR_W'(N_ROUNDS - 1);
    localparam logic [VW-1:0]     VIDAS_INI  = VW'(LIVES);
    localparam logic [VW-1:0]     VIDA_UMA   = VW'(1);

    typedef enum logic [4:0] {
        INICIAL       = 5'd0,
        PREPARA       = 5'd1,
        MOSTRA        = 5'd2,
        MOSTRA_PROX   = 5'd3,
        INICIA_RODADA = 5'd4,
        ESPERA        = 5'd5,
        REGISTRA      = 5'd6,
        COMPARA       = 5'd7,
        PROXIMO       = 5'd8,
        ULTIMA        = 5'd9,
        ESPERA_NOVA   = 5'd10,
        REGISTRA_NOVA = 5'd11,
        ESCREVE       = 5'd12,
        PROX_RODADA   = 5'd13,
        FALHA         = 5'd14,
        FIM_ACERTOU   = 5'd15,
        FIM_ERROU     = 5'd16,
        FIM_TIMEOUT   = 5'd17
    } estado_t;

    estado_t       estado, proximo;
    logic [TW-1:0] tempo;       // shared show/move timer; the two phases never overlap
    logic          modoReg;
    logic          causaTimeout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado       <= INICIAL;
            endereco     <= '0;
            rodada       <= '0;
            tempo        <= '0;
            vidas        <= '0;
            modoReg      <= 1'b0;
            causaTimeout <= 1'b0;
        end else begin
            estado <= proximo;
            case (estado)
                PREPARA: begin
                    endereco <= '0;
                    rodada   <= '0;
                    tempo    <= '0;
                    vidas    <= VIDAS_INI;
                    modoReg  <= modo;
                end
                MOSTRA: if (tempo != SHOW_FIM) tempo <= tempo + 1'b1;
                MOSTRA_PROX: if (endereco != rodada) begin
                    endereco <= endereco + 1'b1;
                    tempo    <= '0;
                end
                INICIA_RODADA: begin
                    endereco <= '0;
                    tempo    <= '0;
                end
                ESPERA, ESPERA_NOVA: begin
                    if (!jogada && tempo != TEMPO_FIM) tempo <= tempo + 1'b1;
                    if (!jogada && tempo == TEMPO_FIM) causaTimeout <= 1'b1;
                end
                COMPARA: if (!igual) causaTimeout <= 1'b0;
                PROXIMO: begin
                    endereco <= endereco + 1'b1;
                    tempo    <= '0;
                end
                ULTIMA: if (rodada != RODADA_FIM && modoReg) begin
                    endereco <= endereco + 1'b1;
                    tempo    <= '0;
                end
                PROX_RODADA: begin
                    rodada   <= rodada + 1'b1;
                    endereco <= '0;
                    tempo    <= '0;
                end
                FALHA: begin
                    vidas <= vidas - 1'b1;
                    if (vidas != VIDA_UMA) begin
                        endereco <= '0;
                        tempo    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        proximo    = estado;
        zeraR      = 1'b0;
        registraR  = 1'b0;
        we         = 1'b0;
        mostra_led = 1'b0;
        acertou    = 1'b0;
        errou      = 1'b0;
        timeout    = 1'b0;
        pronto     = 1'b0;
        case (estado)
            INICIAL: begin
                zeraR = 1'b1;
                if (iniciar) proximo = PREPARA;
            end
            PREPARA: begin
                zeraR   = 1'b1;
                proximo = MOSTRA;
            end
            MOSTRA: begin
                mostra_led = 1'b1;
                if (tempo == SHOW_FIM) proximo = MOSTRA_PROX;
            end
            MOSTRA_PROX:   proximo = (endereco == rodada) ? INICIA_RODADA : MOSTRA;
            INICIA_RODADA: proximo = ESPERA;
            ESPERA: begin
                if (jogada)                  proximo = REGISTRA;
                else if (tempo == TEMPO_FIM) proximo = FALHA;
            end
            REGISTRA: begin
                registraR = 1'b1;
                proximo   = COMPARA;
            end
            COMPARA: begin
                if (!igual)                  proximo = FALHA;
                else if (endereco == rodada) proximo = ULTIMA;
                else                         proximo = PROXIMO;
            end
            PROXIMO: proximo = ESPERA;
            ULTIMA: begin
                if (rodada == RODADA_FIM) proximo = FIM_ACERTOU;
                else if (modoReg)         proximo = ESPERA_NOVA;
                else                      proximo = PROX_RODADA;
            end
            ESPERA_NOVA: begin
                if (jogada)                  proximo = REGISTRA_NOVA;
                else if (tempo == TEMPO_FIM) proximo = FALHA;
            end
            REGISTRA_NOVA: begin
                registraR = 1'b1;
                proximo   = ESCREVE;
            end
            ESCREVE: begin
                we      = 1'b1;
                proximo = PROX_RODADA;
            end
            PROX_RODADA: proximo = MOSTRA;
            FALHA: begin
                zeraR = 1'b1;
                if (vidas == VIDA_UMA) proximo = causaTimeout ? FIM_TIMEOUT : FIM_ERROU;
                else                   proximo = MOSTRA;
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) proximo = PREPARA;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) proximo = PREPARA;
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (iniciar) proximo = PREPARA;
            end
            default: proximo = INICIAL;
        endcase
    end

    assign db_estado = estado;

endmodule
